// File: rtl/gp_register_bank.sv
// gp_register_bank -- general-purpose register file for the CPU datapath.
//
// NUM_REGS x WIDTH storage, three combinational read ports (R1/R2 plus R3,
// which reads at the port-3 write address), two synchronous write ports
// (port 3 = ALU result, port 4 = load writeback), and a PC alias at PC_IDX.
// With BYPASS=1 a read sees data being written in the same cycle.
// A clear engine zeroes one register per cycle on CLR_REQ.
//
// Ports
//   clk, rst        rising-edge clock, async active-low reset
//   A1, A2          read addresses -> R1, R2
//   A3, WD3, WE3    write port 3 (A3 is also the R3 read address)
//   A4, WD4, WE4    write port 4 (wins over port 3 on the same address)
//   PC_IN           value returned for reads of PC_IDX
//   CLR_REQ         start clear sequence (level, sampled in IDLE)
//   R1, R2, R3      read data
//   CLR_BUSY        clear sequence in progress
//   CLR_DONE        one-cycle pulse after the last register is cleared

// One storage register. A clear takes priority over a write.
module gp_reg_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= wd;
  end
endmodule

module gp_register_bank #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4,
  parameter int PC_IDX   = 15,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [WIDTH-1:0]  WD3,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A4,
  input  logic [WIDTH-1:0]  WD4,
  input  logic              WE4,
  input  logic [WIDTH-1:0]  PC_IN,
  input  logic              CLR_REQ,
  output logic [WIDTH-1:0]  R1,
  output logic [WIDTH-1:0]  R2,
  output logic [WIDTH-1:0]  R3,
  output logic              CLR_BUSY,
  output logic              CLR_DONE
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_req_t;

  state_t                          state_q, state_d;
  logic [ADDR_W-1:0]               cnt_q, cnt_d;
  logic                            clearing;
  wr_req_t                         wr3, wr4;
  logic [NUM_REGS-1:0][WIDTH-1:0]  regs;
  logic [2:0][ADDR_W-1:0]          raddr;
  logic [2:0][WIDTH-1:0]           rdata;

  // Only physical registers that are not the PC alias can be written.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS) && (int'(a) != PC_IDX);
  endfunction

  // ---------------- clear FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (CLR_REQ) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) state_d = S_DONE;
      end
      // DONE always returns to IDLE; a held CLR_REQ restarts from there.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign clearing = (state_q == S_CLEAR);
  assign CLR_BUSY = clearing;
  assign CLR_DONE = (state_q == S_DONE);

  // Writes arriving during CLEAR are dropped, not deferred.
  assign wr3 = '{en: WE3 && !clearing && writable(A3), addr: A3, data: WD3};
  assign wr4 = '{en: WE4 && !clearing && writable(A4), addr: A4, data: WD4};

  // ---------------- storage ----------------
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic             hit3, hit4;
    logic             clr_i;
    logic [WIDTH-1:0] wd_i;

    assign hit3  = wr3.en && (wr3.addr == ADDR_W'(i));
    assign hit4  = wr4.en && (wr4.addr == ADDR_W'(i));
    assign clr_i = clearing && (cnt_q == ADDR_W'(i));
    assign wd_i  = hit4 ? wr4.data : wr3.data;

    gp_reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk (clk),
      .rst (rst),
      .clr (clr_i),
      .we  (hit3 | hit4),
      .wd  (wd_i),
      .q   (regs[i])
    );
  end

  // ---------------- read ports ----------------
  assign raddr = {A3, A2, A1};

  for (genvar p = 0; p < 3; p++) begin : g_rd
    logic [WIDTH-1:0] val;

    always_comb begin
      val = '0;
      if (int'(raddr[p]) == PC_IDX) begin
        val = PC_IN;
      end else if (writable(raddr[p])) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (raddr[p] == ADDR_W'(i)) val = regs[i];
        // wr*.en is already low during CLEAR, so no bypass there.
        if (BYPASS != 0) begin
          if (wr4.en && wr4.addr == raddr[p])      val = wr4.data;
          else if (wr3.en && wr3.addr == raddr[p]) val = wr3.data;
        end
      end
    end

    assign rdata[p] = val;
  end

  assign R1 = rdata[0];
  assign R2 = rdata[1];
  assign R3 = rdata[2];

endmodule
